// File: rtl/ternary_memory_responder.sv
// Memory-side responder for the ternary CPU bus: converts balanced-ternary word
// addresses to a linear index and answers each request after LATENCY wait states.
// Optional compile-time macro: MEM_TRIT_CHECK_EN rejects requests carrying 2'b11 trits.
module ternary_memory_responder #(
    parameter int WORD_SIZE     = 9,
    parameter int MEM_ADDR_SIZE = 4,
    parameter int LATENCY       = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2*MEM_ADDR_SIZE-1:0] mem_address,
    input  logic [2*WORD_SIZE-1:0]     mem_write_data,
    input  logic                       mem_read,
    input  logic                       mem_write,
    output logic [2*WORD_SIZE-1:0]     mem_read_data,
    output logic                       mem_ready,
    output logic                       mem_error
);

    function automatic int pow3(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 3;
        return r;
    endfunction

    localparam int WORD_W = 2 * WORD_SIZE;
    localparam int DEPTH  = pow3(MEM_ADDR_SIZE);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Balanced ternary plus the half-range offset; 2'b11 trits weigh nothing.
    function automatic logic [IDX_W-1:0] addr_to_index(input logic [2*MEM_ADDR_SIZE-1:0] addr);
        int acc;
        int weight;
        acc    = (DEPTH - 1) / 2;
        weight = 1;
        for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
            case (addr[2*i +: 2])
                2'b01:   acc = acc + weight;
                2'b10:   acc = acc - weight;
                default: acc = acc;
            endcase
            weight = weight * 3;
        end
        return acc[IDX_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] clean_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = w;
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (w[2*i +: 2] == 2'b11) r[2*i +: 2] = 2'b00;
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                is_write_q, is_write_d;
    logic [WORD_W-1:0]   mem_read_data_q, mem_read_data_d;
    logic                mem_ready_q, mem_ready_d;
    logic                mem_we;
    logic                rejected;
    logic [WORD_W-1:0]   mem_q [DEPTH];

    // Handshake: mem_read/mem_write are levels sampled only in IDLE; the access
    // happens in RESP and its result is presented, with a one-cycle mem_ready,
    // in the cycle that follows, during which a still-held request is re-sampled.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        wdata_d         = wdata_q;
        is_write_d      = is_write_q;
        mem_read_data_d = mem_read_data_q;
        mem_ready_d     = 1'b0;
        mem_we          = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d      = addr_to_index(mem_address);
                    wdata_d    = clean_word(mem_write_data);
                    is_write_d = mem_write;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                mem_ready_d = 1'b1;
                if (!rejected) begin
                    if (is_write_q) begin
                        mem_we          = 1'b1;
                        mem_read_data_d = wdata_q;
                    end else begin
                        mem_read_data_d = mem_q[idx_q];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            wdata_q         <= '0;
            is_write_q      <= 1'b0;
            mem_read_data_q <= '0;
            mem_ready_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            wdata_q         <= wdata_d;
            is_write_q      <= is_write_d;
            mem_read_data_q <= mem_read_data_d;
            mem_ready_q     <= mem_ready_d;
        end
    end

    // Storage is deliberately not cleared; a reset in RESP drops the commit.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_TRIT_CHECK_EN
    logic reject_q, reject_d;
    logic mem_error_q, mem_error_d;
    logic addr_bad, data_bad;

    always_comb begin
        addr_bad = 1'b0;
        data_bad = 1'b0;
        for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
            if (mem_address[2*i +: 2] == 2'b11) addr_bad = 1'b1;
        end
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (mem_write_data[2*i +: 2] == 2'b11) data_bad = 1'b1;
        end
        reject_d = reject_q;
        if (state_q == IDLE && (mem_read || mem_write)) begin
            reject_d = addr_bad || (mem_write && data_bad);
        end
        mem_error_d = (state_q == RESP) && reject_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reject_q    <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            reject_q    <= reject_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign rejected  = reject_q;
    assign mem_error = mem_error_q;
`else
    assign rejected  = 1'b0;
    assign mem_error = 1'b0;
`endif

    assign mem_read_data = mem_read_data_q;
    assign mem_ready     = mem_ready_q;

endmodule

// File: tb/tb_ternary_memory_responder.sv
// Self-checking bench for ternary_memory_responder: two instances (LATENCY 1 and 3)
// driven with directed and random requests against an index-addressed reference array.
module tb_ternary_memory_responder;

    localparam int WS    = 9;
    localparam int AS    = 4;
    localparam int DEPTH = 81;
    localparam int MID   = (DEPTH - 1) / 2;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;
`ifdef MEM_TRIT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic            clk;
    logic            rst   [2];
    logic [2*AS-1:0] addr  [2];
    logic [2*WS-1:0] wdata [2];
    logic            rd    [2];
    logic            wr    [2];
    logic [2*WS-1:0] rdata [2];
    logic            rdy   [2];
    logic            err   [2];

    int total_cnt;
    int pass_cnt;
    int fail_cnt;
    int lat [2];
    logic [2*WS-1:0] model_mem  [2][DEPTH];
    logic [2*WS-1:0] last_rdata [2];
    logic [2*WS-1:0] exp_q [$];

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    ternary_memory_responder #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .LATENCY(LAT0)) dut_lat1 (
        .clock(clk), .reset(rst[0]), .mem_address(addr[0]), .mem_write_data(wdata[0]),
        .mem_read(rd[0]), .mem_write(wr[0]), .mem_read_data(rdata[0]),
        .mem_ready(rdy[0]), .mem_error(err[0])
    );

    ternary_memory_responder #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .LATENCY(LAT1)) dut_lat3 (
        .clock(clk), .reset(rst[1]), .mem_address(addr[1]), .mem_write_data(wdata[1]),
        .mem_read(rd[1]), .mem_write(wr[1]), .mem_read_data(rdata[1]),
        .mem_ready(rdy[1]), .mem_error(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index -> balanced-ternary digits by repeated division of (index - MID).
    function automatic logic [2*AS-1:0] index_to_addr(input int idx);
        logic [2*AS-1:0] a;
        int n;
        int r;
        a = '0;
        n = idx - MID;
        for (int i = 0; i < AS; i++) begin
            r = ((n % 3) + 3) % 3;
            if (r == 1) begin
                a[2*i +: 2] = 2'b01;
                n = (n - 1) / 3;
            end else if (r == 2) begin
                a[2*i +: 2] = 2'b10;
                n = (n + 1) / 3;
            end else begin
                n = n / 3;
            end
        end
        return a;
    endfunction

    function automatic logic [2*AS-1:0] poison_zero_trits(input logic [2*AS-1:0] a, output bit bad);
        logic [2*AS-1:0] r;
        r   = a;
        bad = 1'b0;
        for (int i = 0; i < AS; i++) begin
            if (a[2*i +: 2] == 2'b00 && $urandom_range(0, 1) == 1) begin
                r[2*i +: 2] = 2'b11;
                bad = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [2*WS-1:0] rand_word(input bit allow_bad);
        logic [2*WS-1:0] w;
        int c;
        for (int i = 0; i < WS; i++) begin
            c = $urandom_range(0, allow_bad ? 3 : 2);
            w[2*i +: 2] = 2'(c);
        end
        return w;
    endfunction

    function automatic logic [2*WS-1:0] clean_word(input logic [2*WS-1:0] w, output bit bad);
        logic [2*WS-1:0] r;
        r   = w;
        bad = 1'b0;
        for (int i = 0; i < WS; i++) begin
            if (w[2*i +: 2] == 2'b11) begin
                r[2*i +: 2] = 2'b00;
                bad = 1'b1;
            end
        end
        return r;
    endfunction

    // Driver: one complete request, checked cycle by cycle; called at a negedge.
    task automatic xact(input int w, input logic r_en, input logic w_en, input int idx,
                        input logic [2*AS-1:0] a_raw, input bit a_bad,
                        input logic [2*WS-1:0] d_raw, input string tag);
        logic [2*WS-1:0] d_clean;
        logic [2*WS-1:0] prev;
        logic [2*WS-1:0] exp_data;
        bit d_bad;
        bit rej;
        d_clean = clean_word(d_raw, d_bad);
        rej  = CHECK_EN && (a_bad || (w_en && d_bad));
        prev = last_rdata[w];
        if (rej) begin
            exp_data = prev;
        end else if (w_en) begin
            model_mem[w][idx] = d_clean;
            exp_data = d_clean;
        end else begin
            exp_data = model_mem[w][idx];
        end
        last_rdata[w] = exp_data;
        exp_q.push_back(exp_data);

        addr[w]  = a_raw;
        wdata[w] = d_raw;
        rd[w]    = r_en;
        wr[w]    = w_en;
        for (int c = 0; c <= lat[w] + 1; c++) begin
            @(negedge clk);
            check($sformatf("%s ready cyc%0d", tag, c), 32'(rdy[w]), (c == lat[w] + 1) ? 32'd1 : 32'd0);
            if (c == 0) check({tag, " data held while busy"}, 32'(rdata[w]), 32'(prev));
        end
        exp_data = exp_q.pop_front();
        check({tag, " data"}, 32'(rdata[w]), 32'(exp_data));
        check({tag, " error"}, 32'(err[w]), 32'(rej));
        rd[w] = 1'b0;
        wr[w] = 1'b0;
        @(negedge clk);
        check({tag, " ready one cycle"}, 32'(rdy[w]), 32'd0);
        check({tag, " data holds"}, 32'(rdata[w]), 32'(exp_data));
    endtask

    initial begin
        int w;
        int idx;
        int op;
        bit ab;
        logic [2*AS-1:0] a;
        logic [2*WS-1:0] d;
        logic [2*WS-1:0] old;

        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        lat[0]    = LAT0;
        lat[1]    = LAT1;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; addr[k] = '0; wdata[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0;
            last_rdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset ready i%0d", k), 32'(rdy[k]), 32'd0);
            check($sformatf("reset error i%0d", k), 32'(err[k]), 32'd0);
            check($sformatf("reset data i%0d", k), 32'(rdata[k]), 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Populate every location so later reads have a known expectation.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                d = (i == MID) ? 18'd0 : rand_word(1'b0);
                xact(k, 1'b0, 1'b1, i, index_to_addr(i), 1'b0, d, "fill");
            end
        end

        xact(0, 1'b1, 1'b0, MID, index_to_addr(MID), 1'b0, '0, "read all-zero addr");
        check("all-zero addr encodes index 40", 32'(index_to_addr(MID)), 32'd0);
        check("all -1 addr encodes index 0", 32'(index_to_addr(0)), 32'h0000_00aa);
        check("all +1 addr encodes index 80", 32'(index_to_addr(DEPTH - 1)), 32'h0000_0055);

        xact(0, 1'b0, 1'b1, 0, index_to_addr(0), 1'b0, 18'h00001, "write +1 to index 0");
        xact(0, 1'b1, 1'b0, 0, index_to_addr(0), 1'b0, '0, "read index 0");

        xact(0, 1'b0, 1'b1, DEPTH - 1, index_to_addr(DEPTH - 1), 1'b0, rand_word(1'b0), "write index 80");
        xact(0, 1'b1, 1'b0, MID, index_to_addr(MID), 1'b0, '0, "read index 40 untouched");
        xact(0, 1'b1, 1'b0, DEPTH - 1, index_to_addr(DEPTH - 1), 1'b0, '0, "read index 80");

        idx = $urandom_range(0, DEPTH - 1);
        xact(0, 1'b1, 1'b1, idx, index_to_addr(idx), 1'b0, rand_word(1'b0), "read+write");
        xact(0, 1'b1, 1'b0, idx, index_to_addr(idx), 1'b0, '0, "readback after read+write");

        a = index_to_addr(MID);
        a[3:2] = 2'b11;
        xact(0, 1'b1, 1'b0, MID, a, 1'b1, '0, "addr trit1 invalid");

        for (int n = 0; n < 60; n++) begin
            w   = $urandom_range(0, 1);
            idx = $urandom_range(0, DEPTH - 1);
            op  = $urandom_range(0, 2);
            a   = index_to_addr(idx);
            ab  = 1'b0;
            if ($urandom_range(0, 4) == 0) a = poison_zero_trits(a, ab);
            d   = rand_word($urandom_range(0, 3) == 0);
            xact(w, op != 1, op != 0, idx, a, ab, d, $sformatf("rand%0d", n));
        end

        // Reset wins over a request sampled on the same edge.
        rd[0]   = 1'b1;
        addr[0] = index_to_addr(MID);
        rst[0]  = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        rd[0]  = 1'b0;
        last_rdata[0] = '0;
        for (int c = 0; c < LAT0 + 3; c++) begin
            @(negedge clk);
            check($sformatf("reset priority no ready cyc%0d", c), 32'(rdy[0]), 32'd0);
        end
        check("reset priority data cleared", 32'(rdata[0]), 32'd0);

        // Reset during WAIT discards the pending write on the LATENCY=3 instance.
        idx = 5;
        old = model_mem[1][idx];
        d   = ~old & 18'h15555;
        addr[1]  = index_to_addr(idx);
        wdata[1] = d;
        wr[1]    = 1'b1;
        @(negedge clk);
        rst[1] = 1'b1;
        wr[1]  = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        last_rdata[1] = '0;
        for (int c = 0; c < LAT1 + 3; c++) begin
            @(negedge clk);
            check($sformatf("reset in wait no ready cyc%0d", c), 32'(rdy[1]), 32'd0);
        end
        check("reset in wait data cleared", 32'(rdata[1]), 32'd0);
        xact(1, 1'b1, 1'b0, idx, index_to_addr(idx), 1'b0, '0, "read after aborted write");
        check("aborted write left old contents", 32'(model_mem[1][idx]), 32'(old));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
